apb_controller: RTL and testbench



---
 rtl/ahb2apb_pkg.sv | 25 ++
 rtl/apb_controller_if.sv | 45 ++++
 rtl/apb_controller.sv | 146 ++++++++++++++
 tb/tb_apb_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared widths, FSM state encoding and request payload for the AHB-to-APB bridge.
// The macro APB_PREADY_EN is not used here. It is consumed by
// apb_controller_if.sv and apb_controller.sv.
package ahb2apb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WWAIT   = 3'd1,
        ST_WSETUP  = 3'd2,
        ST_WENABLE = 3'd3,
        ST_RSETUP  = 3'd4,
        ST_RENABLE = 3'd5
    } state_e;

    // Address-phase payload held while a write waits for its data phase.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
    } apb_req_t;

endpackage

// File: rtl/apb_controller_if.sv
// Bus bundle between the AHB slave front end, apb_controller and apb_interface.
//   AHB side : valid, hwrite, haddr, hwdata, tempselx -> controller;
//              hreadyout, hrdata <- controller
//   APB side : pwrite, penable, psel, paddr, pwdata <- controller;
//              prdata (and pready with APB_PREADY_EN) -> controller
// modport master : the controller (APB master sequencer).
// modport slave  : its environment (AHB front end plus APB peripheral side).
// Macro APB_PREADY_EN adds the pready wait-state input.
interface apb_controller_if;
    import ahb2apb_pkg::*;

    logic              valid;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic [SEL_W-1:0]  tempselx;
    logic [DATA_W-1:0] prdata;
`ifdef APB_PREADY_EN
    logic              pready;
`endif
    logic              pwrite;
    logic              penable;
    logic [SEL_W-1:0]  psel;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              hreadyout;
    logic [DATA_W-1:0] hrdata;

    modport master (
`ifdef APB_PREADY_EN
        input  pready,
`endif
        input  valid, hwrite, haddr, hwdata, tempselx, prdata,
        output pwrite, penable, psel, paddr, pwdata, hreadyout, hrdata
    );

    modport slave (
`ifdef APB_PREADY_EN
        output pready,
`endif
        output valid, hwrite, haddr, hwdata, tempselx, prdata,
        input  pwrite, penable, psel, paddr, pwdata, hreadyout, hrdata
    );

endinterface

// File: rtl/apb_controller.sv
// APB master sequencer of the AHB2APB bridge.
// It accepts one AHB request while idle. It then runs an APB SETUP/ACCESS
// transfer and holds hreadyout low until the transfer completes.
// Ports:
//   hclk   : bridge clock, rising edge
//   hreset : asynchronous, active-high reset
//   bus    : apb_controller_if.master (AHB request/response + APB master signals)
// Macro APB_PREADY_EN: when defined, ACCESS is extended while bus.pready is low.
// When undefined, ACCESS always lasts exactly one cycle.
module apb_controller
    import ahb2apb_pkg::*;
(
    input  logic              hclk,
    input  logic              hreset,
    apb_controller_if.master  bus
);

    state_e            state_q,     state_d;
    apb_req_t          req_q,       req_d;
    logic [SEL_W-1:0]  psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic [DATA_W-1:0] hrdata_q,    hrdata_d;
    logic              hreadyout_q, hreadyout_d;

    logic access_done_c;
    logic accept_c;
    logic go_idle_c;

`ifdef APB_PREADY_EN
    assign access_done_c = bus.pready;
`else
    assign access_done_c = 1'b1;
`endif

    // A request is taken only while idle and when it addresses a peripheral.
    assign accept_c = bus.valid && (bus.tempselx != '0);

    // State and registered outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    // Next state plus next output values. The outputs are loaded on the edge
    // that enters the state which owns them, so they appear registered.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hrdata_d    = hrdata_q;
        hreadyout_d = hreadyout_q;
        go_idle_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    req_d       = '{addr: bus.haddr, sel: bus.tempselx};
                    hreadyout_d = 1'b0;
                    if (bus.hwrite) begin
                        state_d = ST_WWAIT;
                    end else begin
                        // Reads skip the data wait, so SETUP is driven straight from the bus.
                        state_d   = ST_RSETUP;
                        psel_d    = bus.tempselx;
                        paddr_d   = bus.haddr;
                        pwrite_d  = 1'b0;
                        penable_d = 1'b0;
                    end
                end
            end
            ST_WWAIT: begin
                // hwdata arrives in the AHB data phase, one cycle after the address.
                pwdata_d  = bus.hwdata;
                psel_d    = req_q.sel;
                paddr_d   = req_q.addr;
                pwrite_d  = 1'b1;
                penable_d = 1'b0;
                state_d   = ST_WSETUP;
            end
            ST_WSETUP: begin
                penable_d = 1'b1;
                state_d   = ST_WENABLE;
            end
            ST_WENABLE: begin
                go_idle_c = access_done_c;
            end
            ST_RSETUP: begin
                penable_d = 1'b1;
                state_d   = ST_RENABLE;
            end
            ST_RENABLE: begin
                if (access_done_c) begin
                    hrdata_d = bus.prdata;
                end
                go_idle_c = access_done_c;
            end
            default: begin
                go_idle_c = 1'b1;
            end
        endcase

        // paddr and pwdata keep their last values across idle.
        if (go_idle_c) begin
            state_d     = ST_IDLE;
            psel_d      = '0;
            penable_d   = 1'b0;
            pwrite_d    = 1'b0;
            hreadyout_d = 1'b1;
        end
    end

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_controller.sv
// Self-checking bench for apb_controller. Each AHB request is compared
// cycle by cycle against a transaction-level expectation.
// Builds with or without APB_PREADY_EN.
module tb_apb_controller;
    import ahb2apb_pkg::*;

    localparam int unsigned SNAP_W = 1 + SEL_W + 1 + 1 + ADDR_W + DATA_W + DATA_W;
`ifdef APB_PREADY_EN
    localparam int MAX_STALL = 3;
`else
    localparam int MAX_STALL = 0;
`endif

    typedef struct {
        logic              valid;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
        int                stall;
    } txn_t;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    apb_controller_if bus ();

    apb_controller dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Architectural model state: values the outputs must hold between transfers.
    logic [ADDR_W-1:0] exp_paddr;
    logic [DATA_W-1:0] exp_pwdata;
    logic [DATA_W-1:0] exp_hrdata;

    txn_t idle_txn;

    function automatic logic [SNAP_W-1:0] snap();
        return {bus.hreadyout, bus.psel, bus.penable, bus.pwrite,
                bus.paddr, bus.pwdata, bus.hrdata};
    endfunction

    function automatic logic [SNAP_W-1:0] mk(input logic rdy, input logic [SEL_W-1:0] s,
                                             input logic en, input logic wr,
                                             input logic [ADDR_W-1:0] a,
                                             input logic [DATA_W-1:0] wd,
                                             input logic [DATA_W-1:0] rd);
        return {rdy, s, en, wr, a, wd, rd};
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.valid = ($urandom_range(0, 7) != 0);
        t.write = 1'($urandom_range(0, 1));
        t.addr  = ADDR_W'($urandom);
        t.sel   = SEL_W'($urandom_range(0, 7));
        t.data  = DATA_W'($urandom);
        t.stall = $urandom_range(0, MAX_STALL);
        return t;
    endfunction

    task automatic drive_addr(input txn_t t);
        bus.valid    = t.valid;
        bus.hwrite   = t.write;
        bus.haddr    = t.addr;
        bus.tempselx = t.sel;
    endtask

    // Entered just after a rising edge, in a cycle where the DUT must be idle.
    // cur is presented now. nxt is presented (held, not sampled) while the DUT is busy.
    task automatic run_txn(input txn_t cur, input txn_t nxt, input string name);
        logic [SNAP_W-1:0] obs, exp_v;
        drive_addr(cur);
        @(negedge hclk);
        obs = snap();
        exp_v = mk(1'b1, '0, 1'b0, 1'b0, exp_paddr, exp_pwdata, exp_hrdata);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s idle: got %h expected %h", name, obs, exp_v);
        end
        if (!(cur.valid && cur.sel != '0)) begin
            @(posedge hclk); #1;
            obs = snap();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL %s ignored: got %h expected %h", name, obs, exp_v);
            end
            return;
        end
        @(posedge hclk); #1;
        drive_addr(nxt);
        if (cur.write) begin
            bus.hwdata = cur.data;
            @(negedge hclk);
            obs = snap();
            exp_v = mk(1'b0, '0, 1'b0, 1'b0, exp_paddr, exp_pwdata, exp_hrdata);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL %s wdata wait: got %h expected %h", name, obs, exp_v);
            end
            @(posedge hclk); #1;
            bus.hwdata = DATA_W'($urandom);
            exp_pwdata = cur.data;
        end
        exp_paddr = cur.addr;
        @(negedge hclk);
        obs = snap();
        exp_v = mk(1'b0, cur.sel, 1'b0, cur.write, cur.addr, exp_pwdata, exp_hrdata);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s setup: got %h expected %h", name, obs, exp_v);
        end
        @(posedge hclk); #1;
        for (int k = 0; k <= cur.stall; k++) begin
`ifdef APB_PREADY_EN
            bus.pready = (k == cur.stall);
`endif
            bus.prdata = (k == cur.stall) ? cur.data : DATA_W'($urandom);
            @(negedge hclk);
            obs = snap();
            exp_v = mk(1'b0, cur.sel, 1'b1, cur.write, cur.addr, exp_pwdata, exp_hrdata);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL %s access[%0d]: got %h expected %h", name, k, obs, exp_v);
            end
            @(posedge hclk); #1;
        end
`ifdef APB_PREADY_EN
        bus.pready = 1'b1;
`endif
        bus.prdata = DATA_W'($urandom);
        if (!cur.write) exp_hrdata = cur.data;
        obs = snap();
        exp_v = mk(1'b1, '0, 1'b0, 1'b0, exp_paddr, exp_pwdata, exp_hrdata);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s complete: got %h expected %h", name, obs, exp_v);
        end
    endtask

    task automatic test_reset();
        logic [SNAP_W-1:0] obs, exp_v;
        @(negedge hclk);
        obs = snap();
        exp_v = mk(1'b1, '0, 1'b0, 1'b0, '0, '0, '0);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected %h", obs, exp_v);
        end
        hreset = 1'b0;
        exp_paddr = '0;
        exp_pwdata = '0;
        exp_hrdata = '0;
        @(posedge hclk); #1;
    endtask

    task automatic test_single_write();
        txn_t t;
        t = '{valid: 1'b1, write: 1'b1, addr: 32'h8000_0010, sel: 3'b001,
              data: 32'hDEAD_BEEF, stall: 0};
        run_txn(t, idle_txn, "single_write");
    endtask

    task automatic test_single_read();
        txn_t t;
        t = '{valid: 1'b1, write: 1'b0, addr: 32'h8400_0004, sel: 3'b010,
              data: 32'h0000_005A, stall: 0};
        run_txn(t, idle_txn, "single_read");
    endtask

    task automatic test_back_to_back();
        txn_t w, r;
        w = '{valid: 1'b1, write: 1'b1, addr: 32'h8000_0100, sel: 3'b100,
              data: 32'h1234_5678, stall: 0};
        r = '{valid: 1'b1, write: 1'b0, addr: 32'h8000_0200, sel: 3'b010,
              data: 32'hCAFE_F00D, stall: 0};
        run_txn(w, r, "b2b_write");
        run_txn(r, idle_txn, "b2b_read");
    endtask

    task automatic test_sel_zero();
        txn_t t;
        t = '{valid: 1'b1, write: 1'b1, addr: 32'h8000_0300, sel: 3'b000,
              data: 32'h0, stall: 0};
        for (int i = 0; i < 3; i++) run_txn(t, t, "sel_zero");
    endtask

    task automatic test_multihot();
        txn_t t;
        t = '{valid: 1'b1, write: 1'b0, addr: 32'h8000_0404, sel: 3'b111,
              data: 32'h0BAD_CAFE, stall: 0};
        run_txn(t, idle_txn, "multihot");
    endtask

`ifdef APB_PREADY_EN
    task automatic test_pready_stall();
        txn_t r, w;
        r = '{valid: 1'b1, write: 1'b0, addr: 32'h8400_0008, sel: 3'b010,
              data: 32'h0000_00A5, stall: 3};
        w = '{valid: 1'b1, write: 1'b1, addr: 32'h8400_000C, sel: 3'b001,
              data: 32'h5555_AAAA, stall: 2};
        run_txn(r, w, "pready_read");
        run_txn(w, idle_txn, "pready_write");
    endtask
`endif

    // Reset asserted mid-cycle during ACCESS must clear the outputs before the next edge.
    task automatic test_reset_midxfer();
        logic [SNAP_W-1:0] obs, exp_v;
        txn_t t;
        t = '{valid: 1'b1, write: 1'b1, addr: 32'h8000_0500, sel: 3'b100,
              data: 32'h7777_1111, stall: 0};
        drive_addr(t);
`ifdef APB_PREADY_EN
        bus.pready = 1'b0;
`endif
        @(posedge hclk); #1;
        bus.valid = 1'b0;
        bus.hwdata = t.data;
        @(posedge hclk); #1;
        @(posedge hclk); #1;
        tests_run++;
        if (bus.penable !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid in_access: got penable %b expected 1", bus.penable);
        end
        #2 hreset = 1'b1;
        #1;
        obs = snap();
        exp_v = mk(1'b1, '0, 1'b0, 1'b0, '0, '0, '0);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid async: got %h expected %h", obs, exp_v);
        end
        exp_paddr = '0;
        exp_pwdata = '0;
        exp_hrdata = '0;
`ifdef APB_PREADY_EN
        bus.pready = 1'b1;
`endif
        @(negedge hclk);
        hreset = 1'b0;
        @(posedge hclk); #1;
    endtask

    task automatic test_random();
        txn_t q[$];
        for (int i = 0; i < 40; i++) q.push_back(rand_txn());
        q.push_back(idle_txn);
        for (int i = 0; i < 40; i++) run_txn(q[i], q[i + 1], "random");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_txn = '{valid: 1'b0, write: 1'b0, addr: '0, sel: '0, data: '0, stall: 0};
        bus.valid    = 1'b0;
        bus.hwrite   = 1'b0;
        bus.haddr    = '0;
        bus.hwdata   = '0;
        bus.tempselx = '0;
        bus.prdata   = '0;
`ifdef APB_PREADY_EN
        bus.pready   = 1'b1;
`endif
        exp_paddr  = '0;
        exp_pwdata = '0;
        exp_hrdata = '0;

        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_sel_zero();
        test_multihot();
`ifdef APB_PREADY_EN
        test_pready_stall();
`endif
        test_reset_midxfer();
        test_single_read();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
